// File: rtl/bin_to_bcd_display.sv
// Serial double-dabble binary-to-BCD converter driving a
// multiplexed common-anode 7-segment panel with blanking and overflow dash.
module bin_to_bcd_display #(
    parameter int WIDTH       = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    bin,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sh, sh_n;
    logic [BW-1:0]     scr, scr_n, adj;
    logic [CW-1:0]     cnt, cnt_n;
    logic              cap, cap_n;
    logic [BW-1:0]     bcd_n;
    logic              ovf_n, done_n;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        scr_n   = scr;
        cnt_n   = cnt;
        cap_n   = cap;
        bcd_n   = bcd;
        ovf_n   = overflow;
        done_n  = 1'b0;
        adj     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ?
                            scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
        end
        case (state)
            S_IDLE: begin
                if (load) begin
                    sh_n    = bin;
                    scr_n   = '0;
                    cnt_n   = CW'(WIDTH);
                    cap_n   = 64'(bin) > MAXV;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scr_n, sh_n} = {adj, sh} << 1;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                bcd_n   = scr;
                ovf_n   = cap;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sh       <= '0;
            scr      <= '0;
            cnt      <= '0;
            cap      <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            scr      <= scr_n;
            cnt      <= cnt_n;
            cap      <= cap_n;
            bcd      <= bcd_n;
            overflow <= ovf_n;
            done     <= done_n;
        end
    end

    // busy covers the done cycle so the result is visible before a restart
    assign busy = (state != S_IDLE) | done;

    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_n;
    logic [BW-1:0] upper;

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        upper = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib   = bcd[4*i +: 4];
                upper = bcd >> (4 * i);
                blank = (BLANK_LZ != 0) && (i > 0) && (upper == '0);
            end
        end
        if (overflow)   seg_n = 7'b0111111;
        else if (blank) seg_n = 7'b1111111;
        else            seg_n = seg7(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
            seg  <= 7'b1111111;
            an   <= '1;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            seg <= seg_n;
            an  <= ~(DIGITS'(1) << idx);
        end
    end
endmodule
